// File: rtl/dma_seq_pkg.sv
// Shared constants, state encoding and command bundle
// for the DMA job sequencer.
package dma_seq_pkg;

  localparam logic [2:0] STATUS = 3'd0;
  localparam logic [2:0] RADDR  = 3'd1;
  localparam logic [2:0] WADDR  = 3'd2;
  localparam logic [2:0] LEN    = 3'd3;
  localparam logic [2:0] CTRL   = 3'd6;

  // WORD | GO | LEEN
  localparam logic [31:0] CTRL_GO = 32'h0000_008C;
  localparam int DONE_BIT = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_W_CTRL0,
    S_W_STAT0,
    S_W_RADDR,
    S_W_WADDR,
    S_W_LEN,
    S_W_GO,
    S_POLL_WAIT,
    S_POLL_RD,
    S_POLL_RSP,
    S_W_ABORT,
    S_W_CLR,
    S_REPORT
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
  } cmd_t;

  function automatic cmd_t wcmd(
    logic [2:0] a, logic [31:0] d);
    cmd_t c;
    c.wr   = 1'b1;
    c.addr = a;
    c.data = d;
    return c;
  endfunction

  function automatic cmd_t rcmd(logic [2:0] a);
    cmd_t c;
    c.wr   = 1'b0;
    c.addr = a;
    c.data = 32'h0;
    return c;
  endfunction

endpackage

// File: rtl/avm_cmd_port.sv
// Holds one Avalon-MM command across waitrequest
// stalls and pulses cmd_done_o when it is taken.
module avm_cmd_port
  import dma_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        go_i,
  input  cmd_t        cmd_i,
  input  logic        avm_waitrequest_i,
  output logic [2:0]  avm_address_o,
  output logic        avm_write_o,
  output logic        avm_read_o,
  output logic [31:0] avm_writedata_o,
  output logic        cmd_done_o
);

  logic        wr_q;
  logic        rd_q;
  logic [2:0]  addr_q;
  logic [31:0] data_q;

  assign cmd_done_o = (wr_q | rd_q) &
                      ~avm_waitrequest_i;

  // Load a command on go_i, drop the strobe once taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 3'd0;
      data_q <= 32'h0;
    end else if (go_i) begin
      wr_q   <= cmd_i.wr;
      rd_q   <= ~cmd_i.wr;
      addr_q <= cmd_i.addr;
      data_q <= cmd_i.data;
    end else if (cmd_done_o) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end
  end

  assign avm_address_o   = addr_q;
  assign avm_write_o     = wr_q;
  assign avm_read_o      = rd_q;
  assign avm_writedata_o = data_q;

endmodule

// File: rtl/dma_job_sequencer.sv
// Programs dma_0 for one copy job, polls STATUS.DONE
// with a timeout and reports done or error.
module dma_job_sequencer
  import dma_seq_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int POLL_GAP  = 8,
  parameter int MAX_POLLS = 1024
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_src,
  input  logic [31:0]      job_dst,
  input  logic [LEN_W-1:0] job_len,
  output logic             done_valid,
  output logic             done_err,
  output logic             busy,
  output logic [2:0]       avm_address,
  output logic             avm_write,
  output logic             avm_read,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  input  logic             avm_waitrequest
);

  localparam int GW =
    (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PW =
    (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'(POLL_GAP - 1);
  localparam logic [PW-1:0] POLL_LAST =
    PW'(MAX_POLLS - 1);

  state_e           state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic [GW-1:0]    gap_q;
  logic [PW-1:0]    poll_q;
  logic             err_q;
  logic             go_q;
  cmd_t             cmd_q;
  logic             ready_q;
  logic             busy_q;
  logic             dv_q;
  logic             de_q;
  logic             cmd_done;
  logic             bad;
  logic             is_done;
  logic             rd_unused;

  assign bad = (len_q == '0) |
               (|src_q[1:0]) |
               (|dst_q[1:0]) |
               (|len_q[1:0]);

  assign is_done   = avm_readdata[DONE_BIT];
  assign rd_unused = ^(avm_readdata &
                       ~(32'd1 << DONE_BIT));

  avm_cmd_port u_port (
    .clk_i             (clk_clk),
    .rst_ni            (reset_reset_n),
    .go_i              (go_q),
    .cmd_i             (cmd_q),
    .avm_waitrequest_i (avm_waitrequest),
    .avm_address_o     (avm_address),
    .avm_write_o       (avm_write),
    .avm_read_o        (avm_read),
    .avm_writedata_o   (avm_writedata),
    .cmd_done_o        (cmd_done)
  );

  // Job FSM: each command state issues the next
  // command as it leaves, so go_q pulses on entry.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      len_q   <= '0;
      gap_q   <= '0;
      poll_q  <= '0;
      err_q   <= 1'b0;
      go_q    <= 1'b0;
      cmd_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      go_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (job_valid) begin
            src_q   <= job_src;
            dst_q   <= job_dst;
            len_q   <= job_len;
            gap_q   <= '0;
            poll_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bad) begin
            err_q   <= 1'b1;
            dv_q    <= 1'b1;
            de_q    <= 1'b1;
            state_q <= S_REPORT;
          end else begin
            go_q    <= 1'b1;
            cmd_q   <= wcmd(CTRL, 32'h0);
            state_q <= S_W_CTRL0;
          end
        end
        S_W_CTRL0: if (cmd_done) begin
          go_q    <= 1'b1;
          cmd_q   <= wcmd(STATUS, 32'h0);
          state_q <= S_W_STAT0;
        end
        S_W_STAT0: if (cmd_done) begin
          go_q    <= 1'b1;
          cmd_q   <= wcmd(RADDR, src_q);
          state_q <= S_W_RADDR;
        end
        S_W_RADDR: if (cmd_done) begin
          go_q    <= 1'b1;
          cmd_q   <= wcmd(WADDR, dst_q);
          state_q <= S_W_WADDR;
        end
        S_W_WADDR: if (cmd_done) begin
          go_q    <= 1'b1;
          cmd_q   <= wcmd(LEN, 32'(len_q));
          state_q <= S_W_LEN;
        end
        S_W_LEN: if (cmd_done) begin
          go_q    <= 1'b1;
          cmd_q   <= wcmd(CTRL, CTRL_GO);
          state_q <= S_W_GO;
        end
        S_W_GO: if (cmd_done) begin
          gap_q   <= '0;
          state_q <= S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            go_q    <= 1'b1;
            cmd_q   <= rcmd(STATUS);
            state_q <= S_POLL_RD;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_POLL_RD: if (cmd_done) begin
          state_q <= S_POLL_RSP;
        end
        S_POLL_RSP: if (avm_readdatavalid) begin
          if (is_done) begin
            err_q   <= 1'b0;
            go_q    <= 1'b1;
            cmd_q   <= wcmd(STATUS, 32'h0);
            state_q <= S_W_CLR;
          end else if (poll_q == POLL_LAST) begin
            err_q   <= 1'b1;
            go_q    <= 1'b1;
            cmd_q   <= wcmd(CTRL, 32'h0);
            state_q <= S_W_ABORT;
          end else begin
            poll_q  <= poll_q + 1'b1;
            state_q <= S_POLL_WAIT;
          end
        end
        S_W_ABORT: if (cmd_done) begin
          go_q    <= 1'b1;
          cmd_q   <= wcmd(STATUS, 32'h0);
          state_q <= S_W_CLR;
        end
        S_W_CLR: if (cmd_done) begin
          dv_q    <= 1'b1;
          de_q    <= err_q;
          state_q <= S_REPORT;
        end
        S_REPORT: begin
          dv_q    <= 1'b0;
          de_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign job_ready  = ready_q;
  assign busy       = busy_q;
  assign done_valid = dv_q;
  assign done_err   = de_q;

endmodule

// File: tb/tb_dma_job_sequencer.sv
// Directed bench for dma_job_sequencer with a small
// Avalon slave model driven on the falling edge.
module tb_dma_job_sequencer;

  localparam int GAP  = 8;
  localparam int MAXP = 6;

  logic        clk = 1'b0;
  logic        reset_reset_n;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_src;
  logic [31:0] job_dst;
  logic [15:0] job_len;
  logic        done_valid;
  logic        done_err;
  logic        busy;
  logic [2:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  always #5 clk = ~clk;

  dma_job_sequencer #(
    .LEN_W     (16),
    .POLL_GAP  (GAP),
    .MAX_POLLS (MAXP)
  ) dut (
    .clk_clk           (clk),
    .reset_reset_n     (reset_reset_n),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_src           (job_src),
    .job_dst           (job_dst),
    .job_len           (job_len),
    .done_valid        (done_valid),
    .done_err          (done_err),
    .busy              (busy),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  int          cyc = 0;
  int          wait_n = 0;
  int          done_at = 1;
  int          st_cnt = 0;
  bit          pend_rd = 0;
  int          n_rd = 0;
  logic [63:0] log_q[$];
  int          rd_cyc[$];
  bit          held = 0;
  logic [36:0] held_v;
  int          stab_err = 0;
  bit          done_seen = 0;
  logic        done_err_s = 0;
  int          done_cyc = 0;
  int          dv_cnt = 0;
  int          acc_cyc = 0;

  function automatic logic [63:0] ew(
    logic [2:0] a, logic [31:0] d);
    return {27'b0, 1'b0, 1'b1, a, d};
  endfunction

  function automatic logic [63:0] er(logic [2:0] a);
    return {27'b0, 1'b1, 1'b0, a, 32'h0};
  endfunction

  // Slave model: stalls wait_n cycles per command,
  // answers reads one cycle later, logs accepted commands.
  always @(negedge clk) begin
    cyc++;
    if (!reset_reset_n) begin
      st_cnt            = 0;
      pend_rd           = 0;
      held              = 0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
    end else begin
      avm_readdatavalid = pend_rd;
      pend_rd = 0;
      if (avm_readdatavalid)
        avm_readdata = (done_at != 0 && n_rd >= done_at)
                       ? 32'h1 : 32'h2;
      else
        avm_readdata = 32'h0;
      if (held &&
          {avm_write, avm_read, avm_address,
           avm_writedata} !== held_v)
        stab_err++;
      held = 0;
      if (avm_write || avm_read) begin
        if (st_cnt < wait_n) begin
          avm_waitrequest = 1'b1;
          st_cnt++;
          held   = 1;
          held_v = {avm_write, avm_read, avm_address,
                    avm_writedata};
        end else begin
          avm_waitrequest = 1'b0;
          st_cnt = 0;
          log_q.push_back({27'b0, avm_read, avm_write,
                           avm_address,
                           avm_read ? 32'h0 : avm_writedata});
          if (avm_read) begin
            n_rd++;
            pend_rd = 1;
            rd_cyc.push_back(cyc);
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (done_valid) begin
        dv_cnt++;
        done_seen  = 1;
        done_err_s = done_err;
        done_cyc   = cyc;
      end
    end
  end

  task automatic clr();
    log_q.delete();
    rd_cyc.delete();
    n_rd      = 0;
    done_seen = 0;
    dv_cnt    = 0;
    stab_err  = 0;
  endtask

  task automatic start_job(input logic [31:0] s,
                           input logic [31:0] d,
                           input logic [15:0] l);
    @(negedge clk);
    #1;
    clr();
    check("ready_before_job", job_ready, 1);
    acc_cyc   = cyc;
    job_valid = 1'b1;
    job_src   = s;
    job_dst   = d;
    job_len   = l;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_done_seen"}, done_seen, 1);
  endtask

  task automatic check_seq(input string tag,
                           input logic [31:0] s,
                           input logic [31:0] d,
                           input logic [15:0] l,
                           input int nrd,
                           input bit abort);
    logic [63:0] exp[$];
    logic [63:0] got;
    exp.push_back(ew(3'd6, 32'h0));
    exp.push_back(ew(3'd0, 32'h0));
    exp.push_back(ew(3'd1, s));
    exp.push_back(ew(3'd2, d));
    exp.push_back(ew(3'd3, {16'h0, l}));
    exp.push_back(ew(3'd6, 32'h8C));
    for (int i = 0; i < nrd; i++)
      exp.push_back(er(3'd0));
    if (abort)
      exp.push_back(ew(3'd6, 32'h0));
    exp.push_back(ew(3'd0, 32'h0));
    check({tag, "_ncmd"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < log_q.size()) ? log_q[i] : '1;
      check($sformatf("%s_cmd%0d", tag, i), got, exp[i]);
    end
  endtask

  task automatic after_done(input string tag,
                            input logic err);
    check({tag, "_err"}, done_err_s, err);
    @(negedge clk);
    #1;
    check({tag, "_ready_next"}, job_ready, 1);
    check({tag, "_busy_clr"}, busy, 0);
    check({tag, "_pulse_w"}, dv_cnt, 1);
  endtask

  task automatic bad_job(input string tag,
                         input logic [31:0] s,
                         input logic [31:0] d,
                         input logic [15:0] l);
    start_job(s, d, l);
    wait_done(tag);
    check({tag, "_lat"}, done_cyc - acc_cyc, 2);
    check({tag, "_nocmd"}, log_q.size(), 0);
    after_done(tag, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, job_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dv"}, done_valid, 0);
    check({tag, "_de"}, done_err, 0);
    check({tag, "_wr"}, avm_write, 0);
    check({tag, "_rd"}, avm_read, 0);
    check({tag, "_addr"}, avm_address, 0);
    check({tag, "_wdata"}, avm_writedata, 0);
  endtask

  initial begin
    reset_reset_n     = 1'b0;
    job_valid         = 1'b0;
    job_src           = 32'h0;
    job_dst           = 32'h0;
    job_len           = 16'h0;
    avm_readdata      = 32'h0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    #23;
    check_idle_outputs("rst");
    @(negedge clk);
    reset_reset_n = 1'b1;

    wait_n  = 0;
    done_at = 1;
    start_job(32'h0, 32'h1000, 16'd64);
    wait_done("basic");
    check_seq("basic", 32'h0, 32'h1000, 16'd64, 1, 0);
    after_done("basic", 1'b0);

    wait_n = 3;
    start_job(32'h0, 32'h1000, 16'd64);
    wait_done("stall");
    check_seq("stall", 32'h0, 32'h1000, 16'd64, 1, 0);
    check("stall_stable", stab_err, 0);
    after_done("stall", 1'b0);

    wait_n  = 0;
    done_at = 5;
    start_job(32'h2000, 32'h3000, 16'd128);
    wait_done("poll5");
    check_seq("poll5", 32'h2000, 32'h3000, 16'd128, 5, 0);
    for (int i = 1; i < rd_cyc.size(); i++) begin
      check($sformatf("poll5_gap%0d", i),
            (rd_cyc[i] - rd_cyc[i-1] - 1) >= GAP, 1);
      check($sformatf("poll5_even%0d", i),
            rd_cyc[i] - rd_cyc[i-1], rd_cyc[1] - rd_cyc[0]);
    end
    after_done("poll5", 1'b0);

    done_at = 0;
    start_job(32'h4, 32'h8, 16'd4);
    wait_done("tmo");
    check_seq("tmo", 32'h4, 32'h8, 16'd4, MAXP, 1);
    after_done("tmo", 1'b1);

    done_at = 1;
    bad_job("len0", 32'h0, 32'h1000, 16'd0);
    bad_job("src2", 32'h2, 32'h1000, 16'd64);
    bad_job("dst1", 32'h0, 32'h1001, 16'd64);
    bad_job("len6", 32'h0, 32'h1000, 16'd6);

    @(negedge clk);
    #1;
    clr();
    job_valid = 1'b1;
    job_src   = 32'h100;
    job_dst   = 32'h200;
    job_len   = 16'd8;
    @(posedge clk);
    #1;
    job_src = 32'h300;
    job_dst = 32'h304;
    job_len = 16'd16;
    repeat (10) @(negedge clk);
    #1;
    check("hold_ready_low", job_ready, 0);
    check("hold_busy", busy, 1);
    job_valid = 1'b0;
    wait_done("hold");
    check_seq("hold", 32'h100, 32'h200, 16'd8, 1, 0);
    after_done("hold", 1'b0);

    wait_n = 3;
    start_job(32'h10, 32'h20, 16'd32);
    for (int i = 0; i < 300 &&
         !(avm_write && avm_address == 3'd3); i++) begin
      @(negedge clk);
      #1;
    end
    check("mid_wlen_seen",
          avm_write && avm_address == 3'd3, 1);
    reset_reset_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    reset_reset_n = 1'b1;
    wait_n = 0;
    start_job(32'h40, 32'h80, 16'd16);
    wait_done("after_rst");
    check_seq("after_rst", 32'h40, 32'h80, 16'd16, 1, 0);
    after_done("after_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
